// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 key-state decoder: key map, prefix bytes, FSM states.
package kbd_pkg;

  localparam int unsigned KEY_COUNT   = 16;
  localparam int unsigned KEY_IDX_W   = 4;
  localparam int unsigned NORMAL_KEYS = 12;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  // Entry i is the scan code for key index i; 0-11 normal codes, 12-15 follow an E0 prefix.
  localparam logic [KEY_COUNT-1:0][7:0] KEY_CODES = {
    8'h74, 8'h6B, 8'h72, 8'h75,  // 15..12: right, left, down, up
    8'h5A, 8'h29,                // 11..10: enter, space
    8'h7D, 8'h75, 8'h6C, 8'h74,  //  9..6
    8'h73, 8'h6B, 8'h7A, 8'h72,  //  5..2
    8'h69, 8'h70                 //  1..0
  };

endpackage

// File: rtl/kbd_code_lookup.sv
// Combinational scan-code to key-index lookup; extended codes only match the arrow block.
module kbd_code_lookup
  import kbd_pkg::*;
(
  input  logic [7:0]           code,
  input  logic                 ext,
  output logic                 hit,
  output logic [KEY_IDX_W-1:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < KEY_COUNT; i++) begin
      if ((1'(i >= NORMAL_KEYS) == ext) && (code == KEY_CODES[i])) begin
        hit   = 1'b1;
        index = KEY_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/kbd_key_state_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes and keeps a held/make/break view of 16 keys.
module kbd_key_state_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din_new,
  input  logic [7:0]           din,
  output logic [KEY_COUNT-1:0] keyPressed,
  output logic [KEY_COUNT-1:0] makePulse,
  output logic [KEY_COUNT-1:0] breakPulse,
  output logic                 anyPressed
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  kbd_state_t             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   make_ev, brk_ev, is_prefix;
  logic                   ext_c, hit_c;
  logic [KEY_IDX_W-1:0]   idx_c;
  logic [KEY_COUNT-1:0]   pressed_nxt, make_nxt, brk_nxt;

  assign ext_c     = (state == EXT) || (state == EXT_BRK);
  assign is_prefix = (din == CODE_E0) || (din == CODE_F0);

  kbd_code_lookup u_lookup (
    .code  (din),
    .ext   (ext_c),
    .hit   (hit_c),
    .index (idx_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      keyPressed <= '0;
      makePulse  <= '0;
      breakPulse <= '0;
      anyPressed <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      keyPressed <= pressed_nxt;
      makePulse  <= make_nxt;
      breakPulse <= brk_nxt;
      anyPressed <= |pressed_nxt;
    end
  end

  // A fresh byte always wins over the timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    if (din_new) begin
      cnt_nxt = '0;
      unique case (state)
        IDLE: begin
          if (din == CODE_E0)      state_nxt = EXT;
          else if (din == CODE_F0) state_nxt = BRK;
          else                     make_ev   = 1'b1;
        end
        EXT: begin
          if (din == CODE_F0) begin
            state_nxt = EXT_BRK;
          end else if (din != CODE_E0) begin
            state_nxt = IDLE;
            make_ev   = 1'b1;
          end
        end
        BRK, EXT_BRK: begin
          state_nxt = IDLE;
          brk_ev    = !is_prefix;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Repeated makes and breaks of released keys leave the key map and pulses untouched.
  always_comb begin
    pressed_nxt = keyPressed;
    make_nxt    = '0;
    brk_nxt     = '0;
    if (make_ev && hit_c && !keyPressed[idx_c]) begin
      pressed_nxt[idx_c] = 1'b1;
      make_nxt[idx_c]    = 1'b1;
    end
    if (brk_ev && hit_c && keyPressed[idx_c]) begin
      pressed_nxt[idx_c] = 1'b0;
      brk_nxt[idx_c]     = 1'b1;
    end
  end

endmodule

// File: tb/tb_kbd_key_state_decoder.sv
// Bench for kbd_key_state_decoder: directed scenarios then random byte streams against a prefix-grammar model.
module tb_kbd_key_state_decoder;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din_new = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [15:0] keyPressed, makePulse, breakPulse;
  logic        anyPressed;

  always #5 clk = ~clk;

  kbd_key_state_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .din_new    (din_new),
    .din        (din),
    .keyPressed (keyPressed),
    .makePulse  (makePulse),
    .breakPulse (breakPulse),
    .anyPressed (anyPressed)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: key map straight from the key table, prefixes as flags that expire
  // when the next byte arrives more than T cycles after the previous one.
  logic [7:0]  norm_codes [12] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73,
                                   8'h74, 8'h6C, 8'h75, 8'h7D, 8'h29, 8'h5A};
  logic [7:0]  ext_codes  [4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [15:0] m_held = '0;
  bit          m_ext = 0, m_brk = 0;
  int          m_last = 0;
  int          cyc = 0;

  function automatic int key_of(input logic [7:0] b, input bit ext);
    int r = -1;
    if (ext) begin
      for (int i = 0; i < 4; i++) if (ext_codes[i] == b) r = 12 + i;
    end else begin
      for (int i = 0; i < 12; i++) if (norm_codes[i] == b) r = i;
    end
    return r;
  endfunction

  task automatic cycle(input bit rst, input bit nw, input logic [7:0] b, input string tag);
    logic [15:0] em = '0, eb = '0;
    int k;
    @(negedge clk);
    reset = rst; din_new = nw; din = b;
    if (rst) begin
      m_held = '0; m_ext = 0; m_brk = 0;
    end else if (nw) begin
      if ((m_ext || m_brk) && (cyc - m_last > int'(T))) begin
        m_ext = 0; m_brk = 0;
      end
      if (m_brk) begin
        if (b != 8'hE0 && b != 8'hF0) begin
          k = key_of(b, m_ext);
          if (k >= 0 && m_held[k]) begin m_held[k] = 1'b0; eb[k] = 1'b1; end
        end
        m_ext = 0; m_brk = 0;
      end else if (m_ext) begin
        if (b == 8'hF0) m_brk = 1;
        else if (b != 8'hE0) begin
          k = key_of(b, 1);
          if (k >= 0 && !m_held[k]) begin m_held[k] = 1'b1; em[k] = 1'b1; end
          m_ext = 0;
        end
      end else begin
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
          k = key_of(b, 0);
          if (k >= 0 && !m_held[k]) begin m_held[k] = 1'b1; em[k] = 1'b1; end
        end
      end
      m_last = cyc;
    end
    @(posedge clk);
    #1;
    chk({tag, ".held"},  keyPressed, m_held);
    chk({tag, ".make"},  makePulse, em);
    chk({tag, ".break"}, breakPulse, eb);
    chk({tag, ".any"},   16'(anyPressed), 16'(|m_held));
    cyc++;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b0, 1'b1, b, "byte");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, "idle");
  endtask

  int mk10;

  initial begin
    cycle(1'b1, 1'b0, 8'h00, "reset");
    cycle(1'b1, 1'b0, 8'h00, "reset");
    chk("reset_held", keyPressed, 16'h0000);
    idle(2);

    // make/break of numpad 6
    send(8'h74);
    chk("np6_make", makePulse, 16'h0040);
    chk("np6_held", keyPressed, 16'h0040);
    idle(1);
    send(8'hF0); send(8'h74);
    chk("np6_break", breakPulse, 16'h0040);
    chk("np6_released", keyPressed, 16'h0000);

    // extended vs normal 75
    send(8'hE0); send(8'h75);
    chk("up_only", keyPressed, 16'h1000);
    send(8'h75);
    chk("up_np8", keyPressed, 16'h1100);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_released", keyPressed, 16'h0100);
    send(8'hF0); send(8'h75);

    // typematic space
    mk10 = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h29);
      mk10 += int'(makePulse[10]);
    end
    chk("space_one_make", 16'(mk10), 16'd1);
    chk("space_any", 16'(anyPressed), 16'd1);
    send(8'hF0); send(8'h29);

    // stale F0 is dropped; F0 exactly T cycles before still counts
    send(8'hF0); idle(T + 2); send(8'h5A);
    chk("enter_after_timeout", keyPressed, 16'h0800);
    send(8'hF0); idle(T - 1); send(8'h5A);
    chk("enter_break_at_edge", breakPulse, 16'h0800);
    send(8'hF0); idle(T); send(8'h5A);
    chk("enter_make_past_edge", makePulse, 16'h0800);

    // unmapped and spurious breaks
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h70);
    chk("unmapped_held", keyPressed, 16'h0800);
    chk("unmapped_break", breakPulse, 16'h0000);
    send(8'hF0); send(8'h5A);

    // reset mid-sequence while key 6 held
    send(8'h74); send(8'hF0);
    cycle(1'b1, 1'b0, 8'h00, "mid_reset");
    chk("mid_reset_held", keyPressed, 16'h0000);
    chk("mid_reset_break", breakPulse, 16'h0000);
    send(8'h74);
    chk("post_reset_make", makePulse, 16'h0040);

    // random streams
    for (int n = 0; n < 1500; n++) begin
      int r, g;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2, 3, 4: b = norm_codes[$urandom_range(0, 11)];
        5, 6: b = ext_codes[$urandom_range(0, 3)];
        7: b = 8'h1C;
        default: b = 8'($urandom);
      endcase
      r = $urandom_range(0, 9);
      g = (r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, 3)) : int'($urandom_range(T - 1, T + 2));
      idle(g);
      if ($urandom_range(0, 99) == 0) cycle(1'b1, 1'b0, 8'h00, "rand_reset");
      send(b);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
